uart_byte_tx: RTL and testbench

Transmit-only UART byte serializer. On a rising edge of a send request it latches one byte and shifts out an 8N1 frame on a single serial line: start bit, 8 data bits LSB first, stop bit. The bit rate is selectable from a 3-bit code. It sits between a byte-producing controller and the board TX pin, and reports busy state and completion back to the controller.

---
 rtl/uart_byte_tx_pkg.sv | 18 +
 rtl/uart_baud_gen.sv | 24 ++
 rtl/uart_byte_tx.sv | 61 ++++++
 tb/tb_uart_byte_tx.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/uart_byte_tx_pkg.sv
// uart_byte_tx_pkg: baud codes, code-to-divisor lookup and FSM states
package uart_byte_tx_pkg;
    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    typedef enum logic {IDLE, SEND} state_t;

    // Each branch folds to a constant, so only a small mux is built
    function automatic int baud_div(input logic [2:0] code, input int clk_freq);
        return code == BAUD_9600  ? clk_freq / 9600  :
               code == BAUD_19200 ? clk_freq / 19200 :
               code == BAUD_38400 ? clk_freq / 38400 :
               code == BAUD_57600 ? clk_freq / 57600 : clk_freq / 115200;
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit_tick pulse once every DIV cycles while enabled
module uart_baud_gen
    import uart_byte_tx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [2:0] baud_code_i,
    output logic       bit_tick_o
);
    localparam int CW = $clog2(CLK_FREQ / 9600 + 1);

    logic [CW-1:0] cnt_q, cnt_d, last;

    always_comb begin
        last       = CW'(baud_div(baud_code_i, CLK_FREQ) - 1);
        bit_tick_o = en_i && cnt_q == last;
        cnt_d      = (!en_i || bit_tick_o) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) cnt_q <= rst_ni ? cnt_d : '0;
endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 UART byte serializer with selectable baud rate
module uart_byte_tx
    import uart_byte_tx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Sent_en,
    input  logic [7:0] Data_byte,
    input  logic [2:0] Baud_set,
    output logic       Uart_tx,
    output logic       Tx_done,
    output logic       Uart_state
);
    state_t     state_q, state_d;
    logic       sent_en_q;
    logic [7:0] data_q, data_d;
    logic [2:0] code_q, code_d;
    logic [3:0] idx_q, idx_d;
    logic       tx_q, tx_d, done_q, done_d;
    logic       tick, load, last_bit;

    // tick only fires in SEND, so last_bit implies SEND
    assign load     = state_q == IDLE && Sent_en && !sent_en_q;
    assign last_bit = tick && idx_q == 4'd9;

    uart_baud_gen #(.CLK_FREQ(CLK_FREQ)) u_baud (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .en_i       (state_q == SEND),
        .baud_code_i(code_q),
        .bit_tick_o (tick)
    );

    always_ff @(posedge Clk) state_q <= Reset_n ? state_d : IDLE;

    always_comb state_d = state_q == IDLE ? (load ? SEND : IDLE) : (last_bit ? IDLE : SEND);

    // idx_q is the bit currently on the line; a tick moves to bit idx_q+1
    always_comb begin
        data_d = load ? Data_byte : data_q;
        code_d = load ? Baud_set : code_q;
        idx_d  = (load || last_bit) ? '0 : tick ? idx_q + 1'b1 : idx_q;
        tx_d   = load ? 1'b0 : (last_bit || (tick && idx_q == 4'd8)) ? 1'b1 : tick ? data_q[idx_q[2:0]] : tx_q;
        done_d = last_bit;
    end

    always_ff @(posedge Clk) begin
        sent_en_q <= Reset_n ? Sent_en : 1'b0;
        data_q    <= Reset_n ? data_d : '0;
        code_q    <= Reset_n ? code_d : '0;
        idx_q     <= Reset_n ? idx_d : '0;
        tx_q      <= Reset_n ? tx_d : 1'b1;
        done_q    <= Reset_n ? done_d : 1'b0;
    end

    assign Uart_tx    = tx_q;
    assign Tx_done    = done_q;
    assign Uart_state = state_q == SEND;
endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: table-driven and randomized frames checked against a timing model
module tb_uart_byte_tx;
    localparam int CLK_HZ = 50_000_000;

    typedef struct {
        logic [7:0] data;
        logic [2:0] code;
        int         hold;
        bit         noise;
        logic [7:0] exp_rx;
        int         exp_busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sent_en;
    logic [7:0] data_byte;
    logic [2:0] baud_set;
    logic       uart_tx, tx_done, uart_state;
    int         pass_n = 0;
    int         total_n = 0;
    vec_t       vecs[7];

    uart_byte_tx #(.CLK_FREQ(CLK_HZ)) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .Sent_en   (sent_en),
        .Data_byte (data_byte),
        .Baud_set  (baud_set),
        .Uart_tx   (uart_tx),
        .Tx_done   (tx_done),
        .Uart_state(uart_state)
    );

    always #10 clk = ~clk;

    function automatic int tb_div(input logic [2:0] c);
        int rates[8] = '{9600, 19200, 38400, 57600, 115200, 115200, 115200, 115200};
        return CLK_HZ / rates[c];
    endfunction

    // {tx, busy, done} expected t cycles after the start edge
    function automatic logic [2:0] model(input int t, input logic [7:0] d, input int div);
        int n;
        if (t >= 10 * div) return {1'b1, 1'b0, t == 10 * div};
        n = t / div;
        return {n == 0 ? 1'b0 : n == 9 ? 1'b1 : d[3'(n - 1)], 1'b1, 1'b0};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total_n++;
        if (got !== exp) $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        else pass_n++;
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input logic [2:0] c, input int hold,
                             input bit noise, input int exp_busy, input logic [7:0] exp_rx);
        int div, len, bad, first_bad, busy_n, done_n;
        logic [7:0] rx;
        div = tb_div(c);
        len = (10 * div > hold ? 10 * div : hold) + 20;
        bad = 0; first_bad = -1; busy_n = 0; done_n = 0; rx = 8'h00;
        @(negedge clk);
        data_byte = d; baud_set = c; sent_en = 1'b1;
        for (int t = 0; t < len; t++) begin
            @(negedge clk);
            if ({uart_tx, uart_state, tx_done} !== model(t, d, div)) begin
                if (bad == 0) first_bad = t;
                bad++;
            end
            busy_n += int'(uart_state);
            done_n += int'(tx_done);
            if (t >= div && t < 9 * div && t % div == div / 2) rx[3'(t / div - 1)] = uart_tx;
            if (t == hold - 1) sent_en = 1'b0;
            if (noise && t == div / 2) begin
                data_byte = ~d;
                baud_set = c == 3'd0 ? 3'd4 : 3'd0;
            end
            if (noise && t == 3 * div) sent_en = 1'b1;
            if (noise && t == 3 * div + 4) sent_en = 1'b0;
        end
        chk({name, " bad cycles (first at ", $sformatf("%0d", first_bad), ")"}, bad, 0);
        chk({name, " busy cycles"}, busy_n, exp_busy);
        chk({name, " done pulses"}, done_n, 1);
        chk({name, " mid-bit data"}, int'(rx), int'(exp_rx));
    endtask

    initial begin
        int bad, done_n, low_n;
        logic [7:0] d;
        logic [2:0] c;
        vecs[0] = '{8'h00, 3'd4, 3,    1'b0, 8'h00, 4340};
        vecs[1] = '{8'h01, 3'd4, 3,    1'b0, 8'h01, 4340};
        vecs[2] = '{8'hA5, 3'd4, 3,    1'b0, 8'hA5, 4340};
        vecs[3] = '{8'h3C, 3'd4, 5000, 1'b0, 8'h3C, 4340};
        vecs[4] = '{8'h5A, 3'd4, 3,    1'b1, 8'h5A, 4340};
        vecs[5] = '{8'h96, 3'd5, 2,    1'b0, 8'h96, 4340};
        vecs[6] = '{8'hC3, 3'd7, 1,    1'b0, 8'hC3, 4340};

        rst_n = 1'b0; sent_en = 1'b1; data_byte = 8'h01; baud_set = 3'd0;
        @(posedge clk);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if ({uart_tx, uart_state, tx_done} !== 3'b100) bad++;
        end
        chk("reset outputs bad cycles", bad, 0);

        // Sent_en already high at release counts as a start edge
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset start tx", int'(uart_tx), 0);
        chk("post-reset start busy", int'(uart_state), 1);
        repeat (5207) @(negedge clk);
        chk("code0 start bit last cycle", int'(uart_tx), 0);
        @(negedge clk);
        chk("code0 data bit0 first cycle", int'(uart_tx), 1);
        rst_n = 1'b0; sent_en = 1'b0;
        @(negedge clk);
        chk("abort tx", int'(uart_tx), 1);
        chk("abort busy", int'(uart_state), 0);
        rst_n = 1'b1;
        done_n = int'(tx_done); low_n = 0;
        repeat (30) begin
            @(negedge clk);
            done_n += int'(tx_done);
            low_n += int'(!uart_tx);
        end
        chk("abort done pulses", done_n, 0);
        chk("abort tx low cycles", low_n, 0);

        for (int i = 0; i < 7; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].code, vecs[i].hold,
                      vecs[i].noise, vecs[i].exp_busy, vecs[i].exp_rx);

        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            c = 3'($urandom_range(4, 7));
            run_frame($sformatf("rand%0d", i), d, c, int'($urandom_range(1, 20)),
                      1'($urandom_range(0, 1)), 10 * tb_div(c), d);
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
